// File: rtl/led_pulse_pkg.sv
// led_pulse_pkg: shared state encoding and counter sizing for led_pulse_stretch.
package led_pulse_pkg;
  typedef enum logic [1:0] {IDLE, ON, GAP} state_t;
  function automatic int cnt_width(input int on, input int gap);
    return $clog2((on > gap ? on : gap) + 1);
  endfunction
endpackage

// File: rtl/led_pulse_stretch_rise_detect.sv
// rise_detect: registered-history 0->1 edge detector; prev clears on reset so a held-high input counts once.
module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic rise
);
  logic prev;
  always_ff @(posedge clk) prev <= rst ? 1'b0 : in;
  assign rise = in & ~prev;
endmodule

// File: rtl/led_pulse_stretch.sv
// led_pulse_stretch: stretches event pulses into LED blinks with fixed on-time and off-gap.
// Define LED_PULSE_QUEUE_EN to queue events that arrive mid-blink instead of dropping them.
module led_pulse_stretch
  import led_pulse_pkg::*;
#(
  parameter int ON_CYCLES  = 5_000_000,
  parameter int GAP_CYCLES = 2_500_000,
  parameter int QUEUE_MAX  = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic event_in,
  output logic led_out,
  output logic busy,
  output logic drop
);
  localparam int CW = cnt_width(ON_CYCLES, GAP_CYCLES);
  localparam logic [CW-1:0] ON_LOAD  = CW'(ON_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LOAD = CW'(GAP_CYCLES - 1);
  state_t state;
  logic [CW-1:0] cnt;
  logic rise, active, sat, replay, gap_end;
  rise_detect u_rise (.clk(clk), .rst(rst), .in(event_in), .rise(rise));
  assign active  = state != IDLE;
  assign gap_end = state == GAP && cnt == '0;
`ifdef LED_PULSE_QUEUE_EN
  localparam int PW = $clog2(QUEUE_MAX + 1);
  logic [PW-1:0] pending, pend_nx;
  assign sat     = pending == PW'(QUEUE_MAX);
  // a rise in the last GAP cycle is folded in before the replay decision
  assign pend_nx = pending + PW'(rise && active && !sat);
  assign replay  = pend_nx != '0;
  assign busy    = active || pending != '0;
  always_ff @(posedge clk)
    if (rst) pending <= '0;
    else pending <= (gap_end && replay) ? pend_nx - 1'b1 : pend_nx;
`else
  assign sat    = 1'b1;
  assign replay = 1'b0;
  assign busy   = active;
`endif
  always_ff @(posedge clk)
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      led_out <= 1'b0;
      drop    <= 1'b0;
    end else begin
      drop <= rise && active && sat;
      case (state)
        IDLE: if (rise) begin
          state   <= ON;
          cnt     <= ON_LOAD;
          led_out <= 1'b1;
        end
        ON: if (cnt == '0) begin
          state   <= GAP;
          cnt     <= GAP_LOAD;
          led_out <= 1'b0;
        end else cnt <= cnt - 1'b1;
        GAP: if (!gap_end) cnt <= cnt - 1'b1;
        else if (replay) begin
          state   <= ON;
          cnt     <= ON_LOAD;
          led_out <= 1'b1;
        end else state <= IDLE;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_led_pulse_stretch.sv
// tb_led_pulse_stretch: directed vector table plus a reset-mid-blink sequence, ON=4 GAP=2 QUEUE_MAX=2.
module tb_led_pulse_stretch;
`ifdef LED_PULSE_QUEUE_EN
  localparam bit Q = 1'b1;
`else
  localparam bit Q = 1'b0;
`endif
  typedef struct {logic ev, rst, led, busy, drop;} vec_t;
  logic clk = 1'b0, rst = 1'b1, event_in = 1'b0;
  logic led_out, busy, drop;
  int errors = 0, checks = 0;
  vec_t v[$];
  led_pulse_stretch #(.ON_CYCLES(4), .GAP_CYCLES(2), .QUEUE_MAX(2)) dut (
    .clk(clk), .rst(rst), .event_in(event_in), .led_out(led_out), .busy(busy), .drop(drop)
  );
  always #5 clk = ~clk;
  task automatic add(input int n, input logic ev, r, led, bsy, drp);
    vec_t x;
    x.ev = ev; x.rst = r; x.led = led; x.busy = bsy; x.drop = drp;
    repeat (n) v.push_back(x);
  endtask
  task automatic chk(input string nm, input int idx, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %b expected %b", nm, idx, act, exp);
    end
  endtask
  task automatic step(input logic ev, input logic r);
    event_in = ev;
    rst = r;
    @(posedge clk);
    #1;
  endtask
  initial begin
    add(2, 0, 1, 0, 0, 0);
    // single pulse
    add(1, 1, 0, 1, 1, 0); add(3, 0, 0, 1, 1, 0); add(2, 0, 0, 0, 1, 0); add(2, 0, 0, 0, 0, 0);
    // level held 20 cycles
    add(4, 1, 0, 1, 1, 0); add(2, 1, 0, 0, 1, 0); add(14, 1, 0, 0, 0, 0); add(2, 0, 0, 0, 0, 0);
    // pulses at 0 and 2
    add(1, 1, 0, 1, 1, 0); add(1, 0, 0, 1, 1, 0); add(1, 1, 0, 1, 1, !Q); add(1, 0, 0, 1, 1, 0);
    add(2, 0, 0, 0, 1, 0);
    if (Q) begin add(4, 0, 0, 1, 1, 0); add(2, 0, 0, 0, 1, 0); end
    add(2, 0, 0, 0, 0, 0);
    // four pulses at 0,2,4,6
    add(1, 1, 0, 1, 1, 0); add(1, 0, 0, 1, 1, 0); add(1, 1, 0, 1, 1, !Q); add(1, 0, 0, 1, 1, 0);
    add(1, 1, 0, 0, 1, !Q); add(1, 0, 0, 0, 1, 0);
    if (Q) begin
      add(1, 1, 0, 1, 1, 1); add(3, 0, 0, 1, 1, 0); add(2, 0, 0, 0, 1, 0);
      add(4, 0, 0, 1, 1, 0); add(2, 0, 0, 0, 1, 0);
    end else add(1, 1, 0, 0, 0, 1);
    add(2, 0, 0, 0, 0, 0);
    // rise in the final GAP cycle
    add(1, 1, 0, 1, 1, 0); add(3, 0, 0, 1, 1, 0); add(2, 0, 0, 0, 1, 0);
    if (Q) begin add(1, 1, 0, 1, 1, 0); add(3, 0, 0, 1, 1, 0); add(2, 0, 0, 0, 1, 0); end
    else add(1, 1, 0, 0, 0, 1);
    add(2, 0, 0, 0, 0, 0);
    // rise in the first IDLE cycle
    add(1, 1, 0, 1, 1, 0); add(3, 0, 0, 1, 1, 0); add(2, 0, 0, 0, 1, 0); add(1, 0, 0, 0, 0, 0);
    add(1, 1, 0, 1, 1, 0); add(3, 0, 0, 1, 1, 0); add(2, 0, 0, 0, 1, 0); add(2, 0, 0, 0, 0, 0);
    // event held high across reset release
    add(2, 1, 1, 0, 0, 0); add(4, 1, 0, 1, 1, 0); add(2, 1, 0, 0, 1, 0); add(2, 1, 0, 0, 0, 0);
    add(2, 0, 0, 0, 0, 0);
    for (int i = 0; i < v.size(); i++) begin
      step(v[i].ev, v[i].rst);
      chk("led_out", i, led_out, v[i].led);
      chk("busy", i, busy, v[i].busy);
      chk("drop", i, drop, v[i].drop);
    end
    // reset during ON with one event pending
    step(1, 0); chk("rst_seq_led", 0, led_out, 1'b1);
    step(0, 0); chk("rst_seq_led", 1, led_out, 1'b1);
    step(1, 0); chk("rst_seq_drop", 2, drop, !Q);
    step(0, 1);
    chk("rst_seq_led", 3, led_out, 1'b0);
    chk("rst_seq_busy", 3, busy, 1'b0);
    chk("rst_seq_drop", 3, drop, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(0, 0);
      chk("rst_seq_led", 4 + i, led_out, 1'b0);
      chk("rst_seq_busy", 4 + i, busy, 1'b0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/led_pulse_stretch.md
# led_pulse_stretch

Output-side companion to the input conditioning stage: turns short internal event pulses (one or more clock cycles) into human-visible LED blinks. Each blink has a guaranteed on-time and a guaranteed off-gap. With queueing compiled in, events arriving mid-blink are counted and replayed in order. It sits between status/event logic and the board LED pins.

## Interface
- `ON_CYCLES`, default 5_000_000: LED-on duration in clk cycles (≥1).
- `GAP_CYCLES`, default 2_500_000: forced LED-off duration after each blink (≥1).
- `QUEUE_MAX`, default 15: saturation value of the pending-blink counter (≥1). Only used with `LED_PULSE_QUEUE_EN`.
- `clk  input  1  system clock; all logic on rising edge`
- `rst  input  1  synchronous reset, active-high`
- `event_in  input  1  event request; each 0→1 transition is one event`
- `led_out  output  1  registered LED drive, high during ON`
- `busy  output  1  high in ON or GAP, or while pending > 0`
- `drop  output  1  one-cycle pulse when an event is discarded`

## Operation
- Rising-edge detect: `prev` register, `rise = event_in & ~prev`. `prev` resets to 0, so `event_in` held high across reset release counts as one event.
- States:
  - IDLE: `led_out=0`. On `rise`, go to ON and load the counter.
  - ON: `led_out=1` for exactly ON_CYCLES cycles, then go to GAP.
  - GAP: `led_out=0` for exactly GAP_CYCLES cycles. At the end, go to ON if pending > 0 (decrement pending in the same cycle), else go to IDLE.
- One down-counter is shared by ON and GAP. Width is `$clog2(max(ON_CYCLES, GAP_CYCLES)+1)`. It reloads on every state entry and never wraps.
- `rise` during ON or GAP:
  - With queueing: pending increments.
  - If pending == QUEUE_MAX, pending saturates and `drop` pulses instead.
- A `rise` in the final GAP cycle is counted into pending first; the end-of-GAP decision sees the updated value. The next blink starts with no IDLE cycle.
- A `rise` in the same cycle that IDLE is entered is not lost: it is registered and handled in IDLE on the next cycle.
- Reset mid-blink: state returns to IDLE, counter=0, pending=0, `led_out=0`, `drop=0`. All queued events are discarded.

## Timing
- Reset values: `led_out=0`, `busy=0`, `drop=0`, state IDLE, pending 0, `prev=0`.
- Latency: `rise` sampled at edge k (from IDLE) → `led_out` high from cycle k+1 through k+ON_CYCLES, low for the next GAP_CYCLES cycles.
- Back-to-back queued blinks: period is exactly ON_CYCLES+GAP_CYCLES.
- `drop` is registered and asserts in the cycle after the offending `rise`.
- `busy` is combinational from state and pending.

## Configuration
- `LED_PULSE_QUEUE_EN` defined:
  - pending counter of width `$clog2(QUEUE_MAX+1)` is present;
  - events during ON/GAP are replayed;
  - `drop` fires only on saturation.
- Not defined:
  - no pending counter;
  - every `rise` during ON or GAP is ignored and pulses `drop`;
  - GAP always returns to IDLE.

## Structure
- Package `led_pulse_pkg`: state enum (IDLE, ON, GAP) and a `cnt_width(on, gap)` constant function.
- One sub-module `rise_detect` (clk, rst, in → rise), reused by other event-driven blocks.
- The FSM, counter and pending logic stay in the top module.

## Test plan
All scenarios use ON=4, GAP=2, QUEUE_MAX=2.
- Single pulse at edge 0 → `led_out` high cycles 1–4, low 5–6; `busy` low from cycle 7.
- Level held high for 20 cycles → exactly one blink; no `drop`.
- Two pulses at edges 0 and 2 (queue on) → high 1–4, low 5–6, high 7–10, low 11–12.
- Four pulses during one blink (queue on) → 1+2 blinks total; `drop` pulses once, one cycle after the fourth pulse.
- Same four pulses with the macro off → one blink; three `drop` pulses.
- `rst` asserted at cycle 3 of ON with pending=1 → next cycle `led_out=0` and `busy=0`; no further blinks.
